nios_onchip_mem_arbiter: RTL

- Two-requester arbiter for the 1024x32 single-port on-chip RAM (byte-enabled, 10-bit word address).
- Port 0 serves the Nios II data master; port 1 serves the camera pixel DMA.
- Presents a single Avalon-MM master toward the RAM: address/byteenable/chipselect/write/writedata/clken.
- Converts the RAM's fixed one-cycle read latency into per-port readdatavalid pulses.
- Round-robin or fixed-priority arbitration, selected by parameter.

---
 rtl/nios_mem_pkg.sv | 23 ++
 rtl/nios_onchip_mem_arbiter_if.sv | 59 +++++
 rtl/nios_rr_arb2.sv | 69 ++++++
 rtl/nios_onchip_mem_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/nios_mem_pkg.sv
// Shared types for the on-chip RAM arbiter: RAM geometry, port ids and the muxed command.
// Pure declarations; no latency or backpressure of its own.
package nios_mem_pkg;

   localparam int MEM_ADDR_W = 10;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = MEM_DATA_W / 8;
   localparam int MEM_RD_LAT = 1;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_BE_W-1:0]   be;
      logic [MEM_DATA_W-1:0] wdata;
      logic                  rd;
      logic                  wr;
   } mem_cmd_t;

endpackage

// File: rtl/nios_onchip_mem_arbiter_if.sv
// Two Avalon-MM requester ports plus the single RAM-side master of the arbiter.
// master = requesters and RAM (drive commands and q); slave = the arbiter itself.
interface nios_onchip_mem_arbiter_if
   import nios_mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);
   localparam int BE_W = DATA_W / 8;

   logic              reset_req;

   logic [ADDR_W-1:0] p0_address;
   logic [BE_W-1:0]   p0_byteenable;
   logic              p0_read;
   logic              p0_write;
   logic [DATA_W-1:0] p0_writedata;
   logic              p0_waitrequest;
   logic [DATA_W-1:0] p0_readdata;
   logic              p0_readdatavalid;

   logic [ADDR_W-1:0] p1_address;
   logic [BE_W-1:0]   p1_byteenable;
   logic              p1_read;
   logic              p1_write;
   logic [DATA_W-1:0] p1_writedata;
   logic              p1_waitrequest;
   logic [DATA_W-1:0] p1_readdata;
   logic              p1_readdatavalid;

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   modport master (
      output reset_req,
      output p0_address, p0_byteenable, p0_read, p0_write, p0_writedata,
      input  p0_waitrequest, p0_readdata, p0_readdatavalid,
      output p1_address, p1_byteenable, p1_read, p1_write, p1_writedata,
      input  p1_waitrequest, p1_readdata, p1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );

   modport slave (
      input  reset_req,
      input  p0_address, p0_byteenable, p0_read, p0_write, p0_writedata,
      output p0_waitrequest, p0_readdata, p0_readdatavalid,
      input  p1_address, p1_byteenable, p1_read, p1_write, p1_writedata,
      output p1_waitrequest, p1_readdata, p1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );

endinterface

// File: rtl/nios_rr_arb2.sv
// Two-way grant: combinational same-cycle grant, round-robin or fixed priority with a
// starvation limit; en_i low withholds all grants so requests simply pend.
module nios_rr_arb2
   import nios_mem_pkg::*;
#(
   parameter int FIXED_PRIO = 0,
   parameter int MAX_CONSEC = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic req0_i,
   input  logic req1_i,
   output logic grant0_o,
   output logic grant1_o
);

   localparam logic [7:0] MAX_C = 8'(MAX_CONSEC);

   port_e      last_grant_q, last_grant_d;
   logic [7:0] consec_cnt_q, consec_cnt_d;

   always_comb begin
      grant0_o = 1'b0;
      grant1_o = 1'b0;
      if (en_i) begin
         if (req0_i && req1_i) begin
            if (FIXED_PRIO != 0) begin
               grant1_o = (consec_cnt_q == MAX_C);
               grant0_o = (consec_cnt_q != MAX_C);
            end else begin
               grant1_o = (last_grant_q == PORT0);
               grant0_o = (last_grant_q == PORT1);
            end
         end else begin
            grant0_o = req0_i;
            grant1_o = req1_i;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant1_o) begin
         last_grant_d = PORT1;
      end else if (grant0_o) begin
         last_grant_d = PORT0;
      end

      // Counts port-0 wins only while port 1 is actually being held off.
      consec_cnt_d = consec_cnt_q;
      if (grant1_o || !req1_i) begin
         consec_cnt_d = 8'd0;
      end else if (grant0_o && consec_cnt_q != MAX_C) begin
         consec_cnt_d = consec_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= PORT1;
         consec_cnt_q <= 8'd0;
      end else begin
         last_grant_q <= last_grant_d;
         consec_cnt_q <= consec_cnt_d;
      end
   end

endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between the Nios data master and the pixel DMA;
// grant is same-cycle, read data returns one cycle later, losers see waitrequest.
module nios_onchip_mem_arbiter
   import nios_mem_pkg::*;
#(
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int DATA_W     = MEM_DATA_W,
   parameter int FIXED_PRIO = 0,
   parameter int MAX_CONSEC = 8
) (
   input logic                     clk,
   input logic                     reset,
   nios_onchip_mem_arbiter_if.slave bus
);

   localparam int BE_W = DATA_W / 8;

   logic     req0, req1;
   logic     grant0, grant1, any_grant;
   mem_cmd_t cmd0, cmd1, sel;

   logic [ADDR_W-1:0] hold_addr_q;
   logic [BE_W-1:0]   hold_be_q;
   logic [DATA_W-1:0] hold_wdata_q;
   logic              rv0_q, rv0_d;
   logic              rv1_q, rv1_d;

   assign req0 = bus.p0_read | bus.p0_write;
   assign req1 = bus.p1_read | bus.p1_write;

   // Reset also gates the grant so the RAM is never selected while state is cleared.
   nios_rr_arb2 #(
      .FIXED_PRIO(FIXED_PRIO),
      .MAX_CONSEC(MAX_CONSEC)
   ) u_arb (
      .clk     (clk),
      .rst     (reset),
      .en_i    (~bus.reset_req & ~reset),
      .req0_i  (req0),
      .req1_i  (req1),
      .grant0_o(grant0),
      .grant1_o(grant1)
   );

   assign cmd0 = '{addr: bus.p0_address, be: bus.p0_byteenable, wdata: bus.p0_writedata,
                   rd: bus.p0_read, wr: bus.p0_write};
   assign cmd1 = '{addr: bus.p1_address, be: bus.p1_byteenable, wdata: bus.p1_writedata,
                   rd: bus.p1_read, wr: bus.p1_write};
   assign sel       = grant1 ? cmd1 : cmd0;
   assign any_grant = grant0 | grant1;

   assign bus.mem_address    = any_grant ? sel.addr  : hold_addr_q;
   assign bus.mem_byteenable = any_grant ? sel.be    : hold_be_q;
   assign bus.mem_writedata  = any_grant ? sel.wdata : hold_wdata_q;
   assign bus.mem_chipselect = any_grant;
   assign bus.mem_write      = any_grant & sel.wr;
   assign bus.mem_clken      = ~bus.reset_req;

   assign bus.p0_waitrequest = req0 & ~grant0;
   assign bus.p1_waitrequest = req1 & ~grant1;

   // A simultaneous read+write is treated as a write; the read never returns data.
   assign rv0_d = grant0 & sel.rd & ~sel.wr;
   assign rv1_d = grant1 & sel.rd & ~sel.wr;

   assign bus.p0_readdatavalid = rv0_q;
   assign bus.p1_readdatavalid = rv1_q;
   assign bus.p0_readdata      = rv0_q ? bus.mem_readdata : '0;
   assign bus.p1_readdata      = rv1_q ? bus.mem_readdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_addr_q  <= '0;
         hold_be_q    <= '0;
         hold_wdata_q <= '0;
         rv0_q        <= 1'b0;
         rv1_q        <= 1'b0;
      end else begin
         if (any_grant) begin
            hold_addr_q  <= sel.addr;
            hold_be_q    <= sel.be;
            hold_wdata_q <= sel.wdata;
         end
         rv0_q <= rv0_d;
         rv1_q <= rv1_d;
      end
   end

endmodule
